// File: rtl/serial_xfer_ctrl.sv
// rtl/serial_xfer_ctrl.sv - frame sequencer for the serial port-demux datapath with clkEN prescaler
module serial_xfer_ctrl #(
    parameter int DIV   = 4,
    parameter int CNT_W = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SerIn,
    input  logic       co1,
    input  logic       co2,
    input  logic       coD,
    output logic       clkEN,
    output logic       sh_en,
    output logic       sh_enD,
    output logic       cnt1,
    output logic       cnt2,
    output logic       ld_cntD,
    output logic       cntD,
    output logic       busy,
    output logic       done,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PORT  = 3'd1,
        S_COUNT = 3'd2,
        S_LOAD  = 3'd3,
        S_CHECK = 3'd4,
        S_XFER  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] pre_cnt;
    logic             tick;
    logic [2:0]       state_q;
    state_t           state_d;

    assign tick = (pre_cnt == PRE_LAST);

    // Gated by reset so the tick reads 0 while held in reset, even with DIV=1.
    assign clkEN = reset & tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_d == S_DONE) && (state_q != S_DONE);
        end
    end

    always_comb begin
        state_d = state_t'(state_q);
        sh_en   = 1'b0;
        sh_enD  = 1'b0;
        cnt1    = 1'b0;
        cnt2    = 1'b0;
        ld_cntD = 1'b0;
        cntD    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tick && !SerIn) state_d = S_PORT;
            end
            S_PORT: begin
                sh_en = 1'b1;
                cnt1  = 1'b1;
                if (tick && co1) state_d = S_COUNT;
            end
            S_COUNT: begin
                sh_enD = 1'b1;
                cnt2   = 1'b1;
                if (tick && co2) state_d = S_LOAD;
            end
            S_LOAD: begin
                ld_cntD = 1'b1;
                if (tick) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (tick) state_d = coD ? S_DONE : S_XFER;
            end
            S_XFER: begin
                cntD = 1'b1;
                if (tick && coD) state_d = S_DONE;
            end
            S_DONE: begin
                if (tick) state_d = S_IDLE;
            end
            // Encoding 7 recovers on the very next clock, tick or not.
            default: state_d = S_IDLE;
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign state = state_q;
endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// tb/tb_serial_xfer_ctrl.sv - self-checking bench for serial_xfer_ctrl
module tb_serial_xfer_ctrl;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PORT  = 3'd1;
    localparam logic [2:0] ST_COUNT = 3'd2;
    localparam logic [2:0] ST_LOAD  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_XFER  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    typedef struct {
        logic [1:0] port;
        logic [4:0] n;
        int         exp_xfer;
        int         exp_done;
    } frame_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic SerIn = 1'b1;
    logic co1, co2, coD;
    logic clkEN, sh_en, sh_enD, cnt1, cnt2, ld_cntD, cntD, busy, done;
    logic [2:0] state;

    logic serin1 = 1'b1;
    logic clken1, sh_en1, sh_end1, cnt1_1, cnt2_1, ld1, cntd1, busy1, done1;
    logic [2:0] state1;

    int checks = 0;
    int errors = 0;

    int n_sh = 0, n_shd = 0, n_ld = 0, n_cntd = 0, n_done = 0;
    logic [2:0] exp_q[$];

    logic       pc;
    logic [2:0] cc;
    logic [4:0] dc;
    logic [1:0] port_sr;
    logic [4:0] cnt_sr;

    always #5 clk = ~clk;

    serial_xfer_ctrl #(.DIV(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .SerIn(SerIn), .co1(co1), .co2(co2), .coD(coD),
        .clkEN(clkEN), .sh_en(sh_en), .sh_enD(sh_enD), .cnt1(cnt1), .cnt2(cnt2),
        .ld_cntD(ld_cntD), .cntD(cntD), .busy(busy), .done(done), .state(state)
    );

    serial_xfer_ctrl #(.DIV(1), .CNT_W(1)) dut1 (
        .clk(clk), .reset(reset), .SerIn(serin1), .co1(1'b0), .co2(1'b0), .coD(1'b0),
        .clkEN(clken1), .sh_en(sh_en1), .sh_enD(sh_end1), .cnt1(cnt1_1), .cnt2(cnt2_1),
        .ld_cntD(ld1), .cntD(cntd1), .busy(busy1), .done(done1), .state(state1)
    );

    // Datapath model: shift registers and the three counters.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= 1'b0; cc <= 3'd0; dc <= 5'd0; port_sr <= 2'd0; cnt_sr <= 5'd0;
        end else if (clkEN) begin
            if (sh_en)  port_sr <= {port_sr[0], SerIn};
            if (cnt1)   pc <= ~pc;
            if (sh_enD) cnt_sr <= {cnt_sr[3:0], SerIn};
            if (cnt2)   cc <= (cc == 3'd4) ? 3'd0 : cc + 3'd1;
            if (ld_cntD)   dc <= cnt_sr;
            else if (cntD) dc <= dc - 5'd1;
        end
    end

    assign co1 = pc;
    assign co2 = (cc == 3'd4);
    assign coD = cntD ? (dc == 5'd1) : (dc == 5'd0);

    always @(negedge clk) begin
        if (done) n_done++;
        if (clkEN) begin
            if (sh_en)   n_sh++;
            if (sh_enD)  n_shd++;
            if (ld_cntD) n_ld++;
            if (cntD)    n_cntd++;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic b, input logic [2:0] exp);
        bit ok;
        logic [2:0] e;
        SerIn = b;
        exp_q.push_back(exp);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            if (clkEN) ok = 1'b1;
        end
        e = exp_q.pop_front();
        if (!ok) begin
            check("tick_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
            check("state_after_tick", int'(state), int'(e));
        end
    endtask

    task automatic run_frame(input frame_t f);
        int sh0, shd0, ld0, cntd0, done0;
        sh0 = n_sh; shd0 = n_shd; ld0 = n_ld; cntd0 = n_cntd; done0 = n_done;
        step(1'b0, ST_PORT);
        step(f.port[1], ST_PORT);
        step(f.port[0], ST_COUNT);
        for (int i = 4; i >= 1; i--) step(f.n[i], ST_COUNT);
        step(f.n[0], ST_LOAD);
        step(1'($urandom_range(0, 1)), ST_CHECK);
        step(1'($urandom_range(0, 1)), (f.n == 5'd0) ? ST_DONE : ST_XFER);
        for (int k = 1; k <= int'(f.n); k++)
            step(1'($urandom_range(0, 1)), (k < int'(f.n)) ? ST_XFER : ST_DONE);
        step(1'b1, ST_IDLE);
        SerIn = 1'b1;
        check("sh_en_ticks", n_sh - sh0, 2);
        check("sh_enD_ticks", n_shd - shd0, 5);
        check("ld_cntD_ticks", n_ld - ld0, 1);
        check("cntD_ticks", n_cntd - cntd0, f.exp_xfer);
        check("done_pulses", n_done - done0, f.exp_done);
        check("port_captured", int'(port_sr), int'(f.port));
        check("count_captured", int'(cnt_sr), int'(f.n));
        check("busy_after_frame", int'(busy), 0);
    endtask

    initial begin
        frame_t frames[4];
        int hi, last, gap_bad, waited, nonidle, hi1;
        frames[0] = '{port: 2'd2, n: 5'd5,  exp_xfer: 5,  exp_done: 1};
        frames[1] = '{port: 2'd1, n: 5'd0,  exp_xfer: 0,  exp_done: 1};
        frames[2] = '{port: 2'd3, n: 5'd31, exp_xfer: 31, exp_done: 1};
        frames[3] = '{port: 2'd0, n: 5'd1,  exp_xfer: 1,  exp_done: 1};

        // Reset state on both instances.
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({clkEN, sh_en, sh_enD, cnt1, cnt2, ld_cntD, cntD, busy, done, state}), 0);
        check("reset_outputs_div1", int'({clken1, busy1, done1, state1}), 0);
        reset = 1'b1;
        #1;
        check("div1_clken_after_release", int'(clken1), 1);

        // Prescaler cadence over 40 clocks.
        hi = 0; last = -1; gap_bad = 0; hi1 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (clkEN) begin
                if (last >= 0 && i - last != 4) gap_bad++;
                last = i;
                hi++;
            end
            if (clken1) hi1++;
        end
        check("clken_count_40", hi, 10);
        check("clken_spacing", gap_bad, 0);
        check("div1_clken_count_40", hi1, 40);

        foreach (frames[i]) run_frame(frames[i]);

        // Reset aborts a frame mid-COUNT.
        step(1'b0, ST_PORT);
        step(1'b1, ST_PORT);
        step(1'b0, ST_COUNT);
        step(1'b1, ST_COUNT);
        #2;
        reset = 1'b0;
        #1;
        check("midframe_reset_outputs", int'({clkEN, sh_en, sh_enD, cnt1, cnt2, ld_cntD, cntD, busy, done, state}), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("held_reset_state", int'(state), 0);
        SerIn = 1'b1;
        reset = 1'b1;
        waited = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            waited++;
            if (clkEN) break;
        end
        check("first_tick_edge_after_release", waited + 1, 4);
        check("no_done_after_abort", int'(done), 0);

        // Idle noise: SerIn held high.
        nonidle = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (state != ST_IDLE || busy) nonidle++;
        end
        check("idle_stays_idle", nonidle, 0);

        // Illegal encoding, injected where the next edge is not a tick.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (clkEN) break;
        end
        @(negedge clk);
        force dut.state_q = 3'd7;
        #1;
        check("forced_illegal_state", int'(state), 7);
        check("forced_illegal_busy", int'(busy), 1);
        release dut.state_q;
        @(posedge clk);
        #1;
        check("illegal_recovers", int'(state), 0);
        check("illegal_recovery_no_tick", int'(clkEN), 0);

        run_frame(frames[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/serial_xfer_ctrl.md
Name: serial_xfer_ctrl

Overview:
- FSM controller that sequences the serial port-demux datapath (port-number shift register, data-count shift register, three counters, demux, seven-segment readout).
- Detects a start bit on SerIn, shifts in a 2-bit port number, then a 5-bit transfer count, loads the down-counter, and routes that many data bits to the selected port.
- Generates the clkEN tick from clk with an internal prescaler, so every datapath step happens on one clkEN-qualified edge.

Parameters:
- DIV, 4, clk cycles per clkEN tick (≥1; DIV=1 means clkEN is held high).
- CNT_W, 3, prescaler counter width (2^CNT_W ≥ DIV).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- SerIn  in  1  serial input line, idle high
- co1  in  1  datapath: port-bit counter at terminal (2nd port bit)
- co2  in  1  datapath: data-count counter at terminal (5th count bit)
- coD  in  1  datapath: transfer down-counter at zero
- clkEN  out  1  one-clk-wide tick every DIV clks
- sh_en  out  1  shift SerIn into port-number register
- sh_enD  out  1  shift SerIn into data-count register
- cnt1  out  1  enable port-bit counter
- cnt2  out  1  enable count-bit counter
- ld_cntD  out  1  load transfer counter from data-count register
- cntD  out  1  enable transfer down-counter
- busy  out  1  high in every state except IDLE
- done  out  1  one-clk pulse at end of frame
- state  out  3  current state encoding (debug/LED)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE (3'd0); prescaler=0; clkEN, sh_en, sh_enD, cnt1, cnt2, ld_cntD, cntD, busy, done all 0. On release, the first clkEN occurs DIV clks later.
- Prescaler: counts 0..DIV-1; clkEN=1 for the one clk where count==DIV-1; wraps to 0. Runs free in all states.
- State transitions only on clk edges where clkEN=1; the state holds otherwise. All control outputs are Moore (decoded from state) except done.
- States and encodings:
  - IDLE (0): all controls 0. If SerIn==0 on a tick, go to PORT (start bit consumed, not shifted).
  - PORT (1): sh_en=1, cnt1=1. Go to COUNT on the tick with co1==1. This takes exactly 2 ticks (2 bits, MSB first).
  - COUNT (2): sh_enD=1, cnt2=1. Go to LOAD on the tick with co2==1. This takes exactly 5 ticks.
  - LOAD (3): ld_cntD=1 for one tick; go to CHECK.
  - CHECK (4): no controls asserted. If coD==1 (count was 0), go to DONE, skipping transfer. Otherwise go to XFER.
  - XFER (5): cntD=1; demux forwards SerIn to P[port]. On the tick with coD==1, go to DONE. The number of XFER ticks equals the loaded count N (1..31).
  - DONE (6): done=1 for exactly one clk (the first clk after entry). Go to IDLE on the next tick.
  - 7 is illegal: go to IDLE on the next clk, with no tick required.
- A start bit during any non-IDLE state is treated as data; there is no resynchronisation.
- Reset asserted mid-frame aborts immediately. Shift-register and counter contents are cleared by their own reset, and no done pulse is generated.
- Frame length in ticks = 1 (start) + 2 + 5 + 1 (LOAD) + 1 (CHECK) + N + 1 (DONE).

Test Plan:
- Reset: hold reset=0 for 3 clks mid-COUNT → state=0, all outputs 0 within the same clk; clkEN first pulses DIV clks after release.
- Prescaler: DIV=4, run 40 clks → clkEN high on exactly 10 clks, spaced 4 apart; DIV=1 → clkEN constant 1.
- Nominal frame: SerIn ticks 0, 1,0, 0,0,1,0,1 (port 2, N=5) → sh_en for 2 ticks, sh_enD for 5, ld_cntD for 1, cntD for 5 ticks, done pulse once; P[2] mirrors SerIn during XFER; SSD shows 05 after load.
- Zero count: port 1, N=0 → CHECK goes straight to DONE; cntD never asserted; done pulses.
- Max count: N=31, port 3 → exactly 31 XFER ticks; back to IDLE with busy=0; a second frame starts on the next start bit.
- Idle noise / illegal state: SerIn held 1 → stays in IDLE indefinitely; force state=7 → IDLE after 1 clk.
